// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, write-op encodings,
// mstatus/mip bit positions and the fixed misa value.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  // Counters live at 0xB00 + offset (low half) and 0xB80 + offset (high half).
  localparam logic [3:0]  CSR_CNT_PAGE = 4'hB;

  typedef enum logic [1:0] {
    WB_NOP = 2'b00,
    WB_RW  = 2'b01,
    WB_RS  = 2'b10,
    WB_RC  = 2'b11
  } wb_op_e;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIP_MTIP     = 7;
  localparam int unsigned MIP_MEIP     = 11;

  localparam logic [31:0] MISA_VAL      = 32'h4000_0100;
  localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;

  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = MSTATUS_MPP_M;
    v[MSTATUS_MIE]  = mie;
    v[MSTATUS_MPIE] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// 64-bit free-running counter with independent low/high word write ports.
// A write to either half suppresses the increment for that cycle.
module csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i) begin
      count_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: ID-stage reads with WB bypass, WB read-modify-write,
// trap entry / mret, interrupt pending, and 64-bit cycle/instret/HPM counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_HPM   = 2,
  parameter int unsigned HART_ID   = 0,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [11:0]                            rd_addr_i,
  output logic [XLEN-1:0]                        rd_data_o,
  output logic                                   rd_illegal_o,
  input  logic                                   wb_en_i,
  input  logic [11:0]                            wb_addr_i,
  input  logic [1:0]                             wb_op_i,
  input  logic [XLEN-1:0]                        wb_src_i,
  input  logic                                   instret_inc_i,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
  input  logic                                   trap_req_i,
  input  logic [XLEN-1:0]                        trap_cause_i,
  input  logic [XLEN-1:0]                        trap_pc_i,
  input  logic [XLEN-1:0]                        trap_tval_i,
  input  logic                                   mret_req_i,
  input  logic                                   ext_irq_i,
  input  logic                                   timer_irq_i,
  output logic                                   irq_pending_o,
  output logic [XLEN-1:0]                        trap_vector_o,
  output logic [XLEN-1:0]                        mret_pc_o
);

  localparam int unsigned NCNT = 2 + NUM_HPM;
  localparam int unsigned IDXW = $clog2(NCNT);

  logic                       mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0]            mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0]            mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [NCNT-1:0][63:0]      cnt_q;
  logic [XLEN-1:0]            mstatus_view, mip_view, tvec_base;
  logic                       rd_hit, wb_hit, wb_ro, wr_act;
  logic                       wb_is_cnt, wb_cnt_hi;
  logic [IDXW-1:0]            wb_cnt_idx;
  logic [XLEN-1:0]            rd_val, wb_old, wb_new, wb_view;
  logic                       unused_cause_bit;

  assign mstatus_view = mstatus_pack(mst_mie_q, mst_mpie_q);

  always_comb begin
    mip_view           = '0;
    mip_view[MIP_MEIP] = ext_irq_i;
    mip_view[MIP_MTIP] = timer_irq_i;
  end

  // Offsets 0, 2..NCNT map to counter slots 0..NCNT-1; offset 1 (time) is absent.
  function automatic logic cnt_decode(input logic [11:0] addr, output logic hi,
                                      output logic [IDXW-1:0] idx);
    logic [6:0] off;
    hi  = addr[7];
    off = addr[6:0];
    idx = '0;
    if (addr[11:8] != CSR_CNT_PAGE || off > 7'(NCNT) || off == 7'd1) begin
      return 1'b0;
    end
    idx = (off == 7'd0) ? '0 : IDXW'(off - 7'd1);
    return 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] csr_read(input logic [11:0] addr, output logic hit);
    logic [XLEN-1:0] val;
    logic            hi;
    logic [IDXW-1:0] idx;
    val = '0;
    hit = 1'b1;
    case (addr)
      CSR_MSTATUS:  val = mstatus_view;
      CSR_MISA:     val = MISA_VAL;
      CSR_MIE:      val = mie_q;
      CSR_MTVEC:    val = mtvec_q;
      CSR_MSCRATCH: val = mscratch_q;
      CSR_MEPC:     val = mepc_q;
      CSR_MCAUSE:   val = mcause_q;
      CSR_MTVAL:    val = mtval_q;
      CSR_MIP:      val = mip_view;
      CSR_MHARTID:  val = XLEN'(HART_ID);
      default: begin
        if (cnt_decode(addr, hi, idx)) begin
          val = hi ? cnt_q[idx][63:32] : cnt_q[idx][31:0];
        end else begin
          hit = 1'b0;
        end
      end
    endcase
    return val;
  endfunction

  always_comb begin
    rd_val    = csr_read(rd_addr_i, rd_hit);
    wb_old    = csr_read(wb_addr_i, wb_hit);
    wb_is_cnt = cnt_decode(wb_addr_i, wb_cnt_hi, wb_cnt_idx);
  end

  assign wb_ro = (wb_addr_i == CSR_MISA) || (wb_addr_i == CSR_MIP) || (wb_addr_i == CSR_MHARTID);

  // Set/clear with a zero mask is a pure read and must not disturb the target.
  always_comb begin
    wb_new = wb_src_i;
    wr_act = 1'b0;
    case (wb_op_e'(wb_op_i))
      WB_RW: begin wb_new = wb_src_i;            wr_act = 1'b1;      end
      WB_RS: begin wb_new = wb_old | wb_src_i;   wr_act = |wb_src_i; end
      WB_RC: begin wb_new = wb_old & ~wb_src_i;  wr_act = |wb_src_i; end
      default: ;
    endcase
    wr_act = wr_act & wb_en_i & wb_hit & ~wb_ro;
  end

  always_comb begin
    wb_view = wb_new;
    if (wb_addr_i == CSR_MSTATUS) begin
      wb_view = MSTATUS_MPP_M | (wb_new & MSTATUS_WMASK);
    end else if (wb_addr_i == CSR_MEPC) begin
      wb_view = {wb_new[XLEN-1:2], 2'b00};
    end
  end

  assign rd_data_o    = (wr_act && wb_addr_i == rd_addr_i) ? wb_view : rd_val;
  assign rd_illegal_o = ~rd_hit;

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (wr_act) begin
      case (wb_addr_i)
        CSR_MSTATUS: begin
          mst_mie_d  = wb_new[MSTATUS_MIE];
          mst_mpie_d = wb_new[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wb_new;
        CSR_MTVEC:    mtvec_d    = wb_new;
        CSR_MSCRATCH: mscratch_d = wb_new;
        CSR_MEPC:     mepc_d     = {wb_new[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wb_new;
        CSR_MTVAL:    mtval_d    = wb_new;
        default: ;
      endcase
    end
    // Trap entry overrides both a same-cycle CSR write and a same-cycle mret.
    if (trap_req_i) begin
      mepc_d     = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d   = trap_cause_i;
      mtval_d    = trap_tval_i;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_req_i) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    logic inc;
    if (g == 0) begin : g_cycle
      assign inc = 1'b1;
    end else if (g == 1) begin : g_instret
      assign inc = instret_inc_i;
    end else begin : g_hpm
      assign inc = hpm_event_i[g-2];
    end
    csr_counter u_counter (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc),
      .wr_lo_i (wr_act && wb_is_cnt && !wb_cnt_hi && wb_cnt_idx == IDXW'(g)),
      .wr_hi_i (wr_act && wb_is_cnt &&  wb_cnt_hi && wb_cnt_idx == IDXW'(g)),
      .wdata_i (wb_new),
      .count_o (cnt_q[g])
    );
  end

  // Vectored mode: base + 4*cause[30:0], truncated to XLEN.
  assign tvec_base     = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_vector_o = (mtvec_q[1:0] == 2'b01 && trap_cause_i[XLEN-1])
                         ? tvec_base + {trap_cause_i[XLEN-3:0], 2'b00}
                         : tvec_base;
  assign unused_cause_bit = trap_cause_i[XLEN-2];

  assign irq_pending_o = mst_mie_q & (|(mie_q & mip_view));
  assign mret_pc_o     = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural CSR model.
module tb_csr_unit;

  localparam int unsigned NUM_HPM   = 2;
  localparam int unsigned HART_ID   = 3;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0101;
  localparam int unsigned NC        = 2 + NUM_HPM;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [11:0]        rd_addr, wb_addr;
  logic [31:0]        rd_data, wb_src, trap_cause, trap_pc, trap_tval, trap_vector, mret_pc;
  logic               rd_illegal, wb_en, instret_inc, trap_req, mret_req;
  logic               ext_irq, timer_irq, irq_pending;
  logic [1:0]         wb_op;
  logic [NUM_HPM-1:0] hpm_event;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Behavioural model state
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cnt [NC];

  logic [11:0] addr_tab [24] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB02,
                                 12'hB03, 12'hB04, 12'hB80, 12'hB82, 12'hB83, 12'hB84,
                                 12'h7C0, 12'hB01, 12'hB05, 12'hC00, 12'hB85, 12'h000};

  always #5 clk = ~clk;

  csr_unit #(
    .XLEN(32), .NUM_HPM(NUM_HPM), .HART_ID(HART_ID), .MTVEC_RST(MTVEC_RST)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_illegal_o(rd_illegal),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_op_i(wb_op), .wb_src_i(wb_src),
    .instret_inc_i(instret_inc), .hpm_event_i(hpm_event),
    .trap_req_i(trap_req), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
    .trap_tval_i(trap_tval), .mret_req_i(mret_req),
    .ext_irq_i(ext_irq), .timer_irq_i(timer_irq), .irq_pending_o(irq_pending),
    .trap_vector_o(trap_vector), .mret_pc_o(mret_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mie_r = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 64'd0;
  endtask

  function automatic logic [31:0] mip_now();
    return (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0);
  endfunction

  function automatic bit cnt_lookup(input logic [11:0] a, output int idx, output bit hi);
    int off;
    idx = -1;
    hi  = 0;
    if (a >= 12'hB80 && a < 12'hBA0) begin hi = 1; off = int'(a) - 'hB80; end
    else if (a >= 12'hB00 && a < 12'hB20) off = int'(a) - 'hB00;
    else return 0;
    if (off == 0) idx = 0;
    else if (off == 2) idx = 1;
    else if (off >= 3 && off < 3 + NUM_HPM) idx = off - 1;
    else return 0;
    return 1;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, output bit ok);
    int idx;
    bit hi;
    ok = 1;
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_r;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return mip_now();
      12'hF14: return HART_ID;
      default: if (cnt_lookup(a, idx, hi)) return hi ? m_cnt[idx][63:32] : m_cnt[idx][31:0];
    endcase
    ok = 0;
    return 32'h0;
  endfunction

  task automatic model_cycle();
    bit wr, ok, wok, hi, old_mie, old_mpie, ev;
    int idx;
    logic [31:0] old_v, nv, exp_rd, base, exp_tv;
    old_v = model_read(wb_addr, wok);
    case (wb_op)
      2'd1:    nv = wb_src;
      2'd2:    nv = old_v | wb_src;
      2'd3:    nv = old_v & ~wb_src;
      default: nv = old_v;
    endcase
    wr = wb_en && wok && !(wb_addr inside {12'h301, 12'h344, 12'hF14})
         && (wb_op == 2'd1 || (wb_op != 2'd0 && wb_src != 0));
    exp_rd = model_read(rd_addr, ok);
    if (wr && wb_addr == rd_addr) begin
      if (wb_addr == 12'h300) exp_rd = 32'h1800 | (nv & 32'h88);
      else if (wb_addr == 12'h341) exp_rd = nv & ~32'h3;
      else exp_rd = nv;
    end
    base = m_mtvec & ~32'h3;
    exp_tv = base;
    if (m_mtvec[1:0] == 2'b01 && trap_cause[31]) exp_tv = base + 32'((trap_cause & 32'h7FFF_FFFF) * 4);
    exp_q.push_back(exp_rd);
    check("rd_data", rd_data, exp_q.pop_front());
    check("rd_illegal", {31'd0, rd_illegal}, {31'd0, !ok});
    check("irq_pending", {31'd0, irq_pending}, {31'd0, m_mie && ((m_mie_r & mip_now()) != 0)});
    check("trap_vector", trap_vector, exp_tv);
    check("mret_pc", mret_pc, m_mepc);
    // state update for the coming edge
    old_mie = m_mie;
    old_mpie = m_mpie;
    for (int i = 0; i < NC; i++) begin
      if (i == 0) ev = 1;
      else if (i == 1) ev = instret_inc;
      else ev = hpm_event[i-2];
      if (wr && cnt_lookup(wb_addr, idx, hi) && idx == i) begin
        if (hi) m_cnt[i][63:32] = nv; else m_cnt[i][31:0] = nv;
      end else if (ev) begin
        m_cnt[i] = m_cnt[i] + 64'd1;
      end
    end
    if (wr) begin
      case (wb_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_r = nv;
        12'h305: m_mtvec = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        default: ;
      endcase
    end
    if (trap_req) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
      m_mpie = old_mie; m_mie = 0;
    end else if (mret_req) begin
      m_mie = old_mpie; m_mpie = 1;
    end
  endtask

  // Compare process: inputs are stable from posedge+1 until the next posedge.
  always @(negedge clk) begin
    if (rst) model_reset();
    else model_cycle();
  end

  // ---------------- driver ----------------
  task automatic next_cycle(); @(posedge clk); #1; endtask
  task automatic mid();        @(negedge clk); #1; endtask

  task automatic idle();
    wb_en = 0; wb_op = 0; wb_src = 0; instret_inc = 0; hpm_event = '0;
    trap_req = 0; mret_req = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] src);
    wb_en = 1; wb_addr = a; wb_op = op; wb_src = src;
  endtask

  task automatic rand_cycle();
    idle();
    rd_addr = addr_tab[$urandom_range(0, 23)];
    wb_addr = ($urandom_range(0, 2) == 0) ? rd_addr : addr_tab[$urandom_range(0, 23)];
    wb_en   = $urandom_range(0, 1);
    wb_op   = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: wb_src = 32'h0;
      1: wb_src = 32'hFFFF_FFFF;
      2: wb_src = 32'($urandom_range(0, 15)) << (4 * $urandom_range(0, 7));
      default: wb_src = $urandom;
    endcase
    instret_inc = $urandom_range(0, 1);
    hpm_event   = NUM_HPM'($urandom);
    ext_irq     = $urandom_range(0, 1);
    timer_irq   = $urandom_range(0, 1);
    trap_req    = ($urandom_range(0, 19) == 0);
    if (trap_req) wb_en = 0;
    trap_cause  = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 40))};
    trap_pc     = $urandom;
    trap_tval   = $urandom;
    mret_req    = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    idle();
    rd_addr = 0; wb_addr = 0; ext_irq = 0; timer_irq = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // reset state
    rd_addr = 12'h305; mid();
    check("rst_mtvec", rd_data, MTVEC_RST);
    check("rst_trap_vector", trap_vector, 32'h0000_0100);
    check("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
    check("rst_mret_pc", mret_pc, 32'd0);
    next_cycle(); rd_addr = 12'h300; mid(); check("rst_mstatus", rd_data, 32'h1800);
    next_cycle(); rd_addr = 12'hB00; mid(); check("rst_mcycle_small", {31'd0, rd_data < 8}, 32'd1);

    // mscratch RW/RS/RC with same-cycle bypass
    next_cycle(); csr_wr(12'h340, 2'd1, 32'hDEAD_BEEF); rd_addr = 12'h340; mid();
    check("mscratch_rw_byp", rd_data, 32'hDEAD_BEEF);
    next_cycle(); csr_wr(12'h340, 2'd2, 32'h0F); mid(); check("mscratch_rs_byp", rd_data, 32'hDEAD_BEEF);
    next_cycle(); csr_wr(12'h340, 2'd3, 32'hF0); mid(); check("mscratch_rc_byp", rd_data, 32'hDEAD_BE0F);
    next_cycle(); idle(); mid(); check("mscratch_final", rd_data, 32'hDEAD_BE0F);

    // trap entry in vectored mode, then mret
    next_cycle(); csr_wr(12'h300, 2'd2, 32'h8); rd_addr = 12'h300; mid(); check("mie_set_byp", rd_data, 32'h1808);
    next_cycle(); csr_wr(12'h305, 2'd1, 32'h1001);
    next_cycle(); idle(); trap_req = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h200; trap_tval = 32'h55;
    mid(); check("trap_vector_vec", trap_vector, 32'h101C);
    next_cycle(); idle(); rd_addr = 12'h300; mid();
    check("trap_mepc", mret_pc, 32'h200);
    check("trap_mstatus", rd_data, 32'h1880);
    next_cycle(); mret_req = 1;
    next_cycle(); idle(); mid(); check("mret_mstatus", rd_data, 32'h1888);

    // minstret carry, then write-beats-increment
    next_cycle(); csr_wr(12'hB02, 2'd1, 32'hFFFF_FFFF);
    next_cycle(); idle(); instret_inc = 1;
    next_cycle(); idle(); rd_addr = 12'hB02; mid(); check("minstret_lo_wrap", rd_data, 32'h0);
    next_cycle(); rd_addr = 12'hB82; mid(); check("minstret_hi_carry", rd_data, 32'h1);
    next_cycle(); csr_wr(12'hB02, 2'd1, 32'h5); instret_inc = 1;
    next_cycle(); idle(); rd_addr = 12'hB02; mid(); check("minstret_wr_wins", rd_data, 32'h5);
    next_cycle(); rd_addr = 12'hB82; mid(); check("minstret_hi_hold", rd_data, 32'h1);

    // interrupt pending
    next_cycle(); csr_wr(12'h304, 2'd1, 32'h800); ext_irq = 1; mid();
    check("irq_before_mie", {31'd0, irq_pending}, 32'd0);
    next_cycle(); idle(); mid(); check("irq_set", {31'd0, irq_pending}, 32'd1);
    next_cycle(); csr_wr(12'h300, 2'd3, 32'h8); mid(); check("irq_same_cycle", {31'd0, irq_pending}, 32'd1);
    next_cycle(); idle(); mid(); check("irq_cleared", {31'd0, irq_pending}, 32'd0);
    ext_irq = 0;

    // unimplemented and read-only addresses
    next_cycle(); rd_addr = 12'h7C0; mid();
    check("illegal_flag", {31'd0, rd_illegal}, 32'd1);
    check("illegal_data", rd_data, 32'd0);
    next_cycle(); csr_wr(12'hF14, 2'd1, 32'h1234); rd_addr = 12'hF14; mid(); check("mhartid_byp", rd_data, HART_ID);
    next_cycle(); idle(); mid(); check("mhartid_ro", rd_data, HART_ID);

    // trap colliding with CSR writes and with mret
    next_cycle(); trap_req = 1; trap_cause = 32'h2; trap_pc = 32'h300; csr_wr(12'h340, 2'd1, 32'h11);
    rd_addr = 12'h340;
    next_cycle(); idle(); mid(); check("trap_wb_other_commits", rd_data, 32'h11);
    next_cycle(); trap_req = 1; trap_cause = 32'h5; trap_pc = 32'h304; csr_wr(12'h341, 2'd1, 32'h999);
    rd_addr = 12'h342;
    next_cycle(); idle(); rd_addr = 12'h341; mid(); check("trap_beats_mepc_wr", rd_data, 32'h304);
    next_cycle(); csr_wr(12'h300, 2'd1, 32'h88); rd_addr = 12'h300;
    next_cycle(); idle(); trap_req = 1; mret_req = 1;
    next_cycle(); idle(); mid(); check("trap_beats_mret", rd_data, 32'h1880);

    // randomized traffic with one asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (n == 1500) begin
        idle();
        rst = 1;
        next_cycle(); next_cycle();
        rst = 0;
        rd_addr = 12'h305; ext_irq = 0; timer_irq = 0; mid();
        check("midrun_rst_mtvec", rd_data, MTVEC_RST);
        next_cycle();
      end
      rand_cycle();
    end

    next_cycle(); idle();
    repeat (2) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
